// File: rtl/line_buffer_rot.sv
// line_buffer_rot
//   Rotating line buffer for the convolution datapath. A raster pixel stream
//   is written round-robin into KER_SIZE single-port SRAM banks, one line per
//   bank. Each accepted pixel reads the same column from every other bank.
//   Once KER_SIZE-1 full lines are held, each accepted pixel produces one
//   kernel column on the output, ordered from the current pixel to the oldest
//   row.
//
// Ports
//   clk        clock
//   rstn       asynchronous active-low reset
//   cfg_width  line width in pixels, taken on an accepted SOF beat
//              (0 or >NW selects NW)
//   in_valid   input pixel valid
//   in_ready   block can accept a pixel
//   in_sof     first pixel of a frame (qualified by the handshake)
//   in_data    input pixel
//   out_valid  kernel column valid
//   out_ready  downstream accepts the column
//   out_data   slice k = bits (k+1)*DW-1:k*DW, k=0 newest, k=KER_SIZE-1 oldest
//   out_eol    column is the last of its line
//   primed     KER_SIZE-1 full lines held since the last SOF
module line_buffer_rot #(
  parameter int KER_SIZE = 3,
  parameter int DW       = 32,
  parameter int NW       = 32,
  parameter int AW       = $clog2(NW)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [AW:0]            cfg_width,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sof,
  input  logic [DW-1:0]          in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [KER_SIZE*DW-1:0] out_data,
  output logic                   out_eol,
  output logic                   primed
);

  localparam int          BW      = $clog2(KER_SIZE);
  localparam logic [AW:0] NW_W    = (AW+1)'(NW);
  localparam logic [BW-1:0] LAST_B = BW'(KER_SIZE-1);

  logic [AW:0]   r_width;
  logic [AW-1:0] r_colCnt;
  logic [BW-1:0] r_wrBank;
  logic [BW-1:0] r_lineCnt;
  logic          r_outValid;
  logic          r_outEol;
  logic [DW-1:0] r_data;
  logic [BW-1:0] r_bankD1;

  logic          w_acc;
  logic [AW:0]   w_widthIn;
  logic [AW:0]   w_widthCur;
  logic [AW-1:0] w_colCur;
  logic [BW-1:0] w_bankCur;
  logic [BW-1:0] w_lineCur;
  logic          w_primedCur;
  logic          w_eolCur;
  logic [BW-1:0] w_bankNext;
  logic [DW-1:0] w_q [KER_SIZE];
  logic [KER_SIZE*DW-1:0] w_outData;

  // Single output stage: a new beat may enter whenever the held column is
  // empty or leaving this cycle, so full throughput has no bubble.
  assign in_ready = !r_outValid || out_ready;
  assign w_acc    = in_valid && in_ready;

  assign w_widthIn = ((cfg_width == '0) || (cfg_width > NW_W)) ? NW_W : cfg_width;

  // An SOF beat is column 0 of bank 0 on line 0 with the new width, no matter
  // where the counters were; this also makes SOF win over a coincident wrap.
  always_comb begin
    w_widthCur = r_width;
    w_colCur   = r_colCnt;
    w_bankCur  = r_wrBank;
    w_lineCur  = r_lineCnt;
    if (in_sof) begin
      w_widthCur = w_widthIn;
      w_colCur   = '0;
      w_bankCur  = '0;
      w_lineCur  = '0;
    end
  end

  assign w_primedCur = (w_lineCur == LAST_B);
  assign w_eolCur    = ({1'b0, w_colCur} == (w_widthCur - (AW+1)'(1)));
  assign w_bankNext  = (w_bankCur == LAST_B) ? '0 : w_bankCur + BW'(1);

  // Column/bank/line counters; line count saturates once primed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_width   <= NW_W;
      r_colCnt  <= '0;
      r_wrBank  <= '0;
      r_lineCnt <= '0;
    end else if (w_acc) begin
      r_width <= w_widthCur;
      if (w_eolCur) begin
        r_colCnt  <= '0;
        r_wrBank  <= w_bankNext;
        r_lineCnt <= (w_lineCur == LAST_B) ? w_lineCur : w_lineCur + BW'(1);
      end else begin
        r_colCnt  <= w_colCur + AW'(1);
        r_wrBank  <= w_bankCur;
        r_lineCnt <= w_lineCur;
      end
    end
  end

  assign primed = (r_lineCnt == LAST_B);

  // SRAM banks: one access per cycle, enabled only on an accepted beat. The
  // bank being written does not read, so its q is stale and never selected.
  for (genvar b = 0; b < KER_SIZE; b++) begin : gBank
    logic [DW-1:0] r_mem [NW];
    logic [DW-1:0] r_q;

    always_ff @(posedge clk) begin
      if (w_acc) begin
        if (w_bankCur == BW'(b)) begin
          r_mem[w_colCur] <= in_data;
        end else begin
          r_q <= r_mem[w_colCur];
        end
      end
    end

    assign w_q[b] = r_q;
  end

  // Pixel and bank index travel alongside the SRAM read so they line up with
  // q in the output cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data   <= '0;
      r_bankD1 <= '0;
    end else if (w_acc) begin
      r_data   <= in_data;
      r_bankD1 <= w_bankCur;
    end
  end

  // Output valid/eol; unprimed beats are stored but produce nothing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_outValid <= 1'b0;
      r_outEol   <= 1'b0;
    end else if (w_acc) begin
      r_outValid <= w_primedCur;
      r_outEol   <= w_eolCur && w_primedCur;
    end else if (out_ready) begin
      r_outValid <= 1'b0;
      r_outEol   <= 1'b0;
    end
  end

  // Generic rotate: slice k comes from the bank written k lines earlier,
  // i.e. (bank_d1 - k) mod KER_SIZE.
  always_comb begin
    w_outData = '0;
    w_outData[DW-1:0] = r_data;
    for (int k = 1; k < KER_SIZE; k++) begin
      int sel;
      sel = int'(r_bankD1) - k;
      if (sel < 0) begin
        sel = sel + KER_SIZE;
      end
      w_outData[k*DW +: DW] = w_q[BW'(sel)];
    end
  end

  assign out_valid = r_outValid;
  assign out_eol   = r_outEol;
  assign out_data  = w_outData;

endmodule

// File: tb/tb_line_buffer_rot.sv
// tb_line_buffer_rot
//   Directed bench for line_buffer_rot. Instance dutA is KER_SIZE=3, DW=8,
//   NW=32 and covers priming, bank rotation, backpressure, mid-line SOF and
//   asynchronous reset. Instance dutB is KER_SIZE=2 and covers the width
//   clamp (cfg_width=0 selects NW). Expected columns are written as
//   {oldest, ..., newest} from the raster position of each pixel.
module tb_line_buffer_rot;

  logic        clk;
  logic        rstn;

  logic [5:0]  cfgWidthA;
  logic        inValidA, inReadyA, inSofA, outValidA, outReadyA, outEolA, primedA;
  logic [7:0]  inDataA;
  logic [23:0] outDataA;

  logic [5:0]  cfgWidthB;
  logic        inValidB, inReadyB, inSofB, outValidB, outReadyB, outEolB, primedB;
  logic [7:0]  inDataB;
  logic [15:0] outDataB;

  int vectorCount = 0;
  int miscompares = 0;

  line_buffer_rot #(.KER_SIZE(3), .DW(8), .NW(32)) dutA (
    .clk(clk), .rstn(rstn), .cfg_width(cfgWidthA),
    .in_valid(inValidA), .in_ready(inReadyA), .in_sof(inSofA), .in_data(inDataA),
    .out_valid(outValidA), .out_ready(outReadyA), .out_data(outDataA),
    .out_eol(outEolA), .primed(primedA)
  );

  line_buffer_rot #(.KER_SIZE(2), .DW(8), .NW(32)) dutB (
    .clk(clk), .rstn(rstn), .cfg_width(cfgWidthB),
    .in_valid(inValidB), .in_ready(inReadyB), .in_sof(inSofB), .in_data(inDataB),
    .out_valid(outValidB), .out_ready(outReadyB), .out_data(outDataB),
    .out_eol(outEolB), .primed(primedB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison funnels through here so the counts stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one pixel on the falling edge, let it be taken on the rising edge,
  // then settle 1 time unit so the caller samples the resulting output.
  task automatic applyStimulus(input logic [7:0] d, input logic sof, input bit toB);
    @(negedge clk);
    if (toB) begin
      inValidB = 1'b1; inSofB = sof; inDataB = d;
    end else begin
      inValidA = 1'b1; inSofA = sof; inDataA = d;
    end
    @(posedge clk);
    #1;
    inValidA = 1'b0; inSofA = 1'b0;
    inValidB = 1'b0; inSofB = 1'b0;
  endtask

  task automatic checkBeatA(input string tag, input bit expValid,
                            input logic [23:0] expData, input bit expEol);
    checkOutput({tag, "_valid"}, 32'(outValidA), 32'(expValid));
    if (expValid) begin
      checkOutput({tag, "_data"}, 32'(outDataA), 32'(expData));
      checkOutput({tag, "_eol"}, 32'(outEolA), 32'(expEol));
    end
  endtask

  initial begin
    logic [23:0] e;
    int v;

    rstn = 1'b0;
    cfgWidthA = 6'd4; inValidA = 1'b0; inSofA = 1'b0; inDataA = '0; outReadyA = 1'b1;
    cfgWidthB = 6'd0; inValidB = 1'b0; inSofB = 1'b0; inDataB = '0; outReadyB = 1'b1;

    #12;
    checkOutput("rst_valid", 32'(outValidA), 32'd0);
    checkOutput("rst_primed", 32'(primedA), 32'd0);
    checkOutput("rst_eol", 32'(outEolA), 32'd0);
    checkOutput("rst_ready", 32'(inReadyA), 32'd1);
    @(negedge clk);
    rstn = 1'b1;

    // Priming and rotation: width 4, pixels 1..18 as one continuous frame.
    $display("[TB] prime and rotation");
    for (int p = 1; p <= 18; p++) begin
      applyStimulus(8'(p), p == 1, 1'b0);
      e = {8'(p - 8), 8'(p - 4), 8'(p)};
      checkBeatA($sformatf("px%0d", p), p >= 9, e, (p % 4) == 0);
      checkOutput($sformatf("px%0d_primed", p), 32'(primedA), 32'(p >= 8));
    end

    // Backpressure: column for pixel 18 is held while pixel 19 waits.
    $display("[TB] backpressure");
    @(negedge clk);
    outReadyA = 1'b0;
    inValidA = 1'b1; inDataA = 8'd19;
    #1;
    checkOutput("bp_ready", 32'(inReadyA), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp%0d_valid", c), 32'(outValidA), 32'd1);
      checkOutput($sformatf("bp%0d_data", c), 32'(outDataA), 32'h0A0E12);
      checkOutput($sformatf("bp%0d_ready", c), 32'(inReadyA), 32'd0);
    end
    @(negedge clk);
    outReadyA = 1'b1;
    @(posedge clk);
    #1;
    inValidA = 1'b0;
    checkBeatA("bp_px19", 1'b1, 24'h0B0F13, 1'b0);
    applyStimulus(8'd20, 1'b0, 1'b0);
    checkBeatA("bp_px20", 1'b1, 24'h0C1014, 1'b1);

    // Six pixels into the next line, then a fresh frame starts mid-line.
    $display("[TB] sof mid-line");
    for (int p = 21; p <= 26; p++) begin
      applyStimulus(8'(p), 1'b0, 1'b0);
      e = {8'(p - 8), 8'(p - 4), 8'(p)};
      checkBeatA($sformatf("px%0d", p), 1'b1, e, (p % 4) == 0);
    end
    for (int n = 0; n < 12; n++) begin
      v = 100 + n;
      applyStimulus(8'(v), n == 0, 1'b0);
      e = {8'(v - 8), 8'(v - 4), 8'(v)};
      checkBeatA($sformatf("f2n%0d", n), n >= 8, e, (n % 4) == 3);
      checkOutput($sformatf("f2n%0d_primed", n), 32'(primedA), 32'(n >= 7));
    end

    // Asynchronous reset between clock edges while a last column is held.
    $display("[TB] async reset");
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(outValidA), 32'd0);
    checkOutput("arst_primed", 32'(primedA), 32'd0);
    checkOutput("arst_eol", 32'(outEolA), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checkOutput("arst_ready", 32'(inReadyA), 32'd1);
    applyStimulus(8'd55, 1'b0, 1'b0);
    checkOutput("arst_nosof_valid", 32'(outValidA), 32'd0);
    checkOutput("arst_nosof_primed", 32'(primedA), 32'd0);

    // Width clamp on the two-row instance: cfg_width 0 means 32 pixels.
    $display("[TB] width clamp");
    for (int n = 0; n < 64; n++) begin
      applyStimulus(8'(n), n == 0, 1'b1);
      checkOutput($sformatf("k2n%0d_valid", n), 32'(outValidB), 32'(n >= 32));
      if (n >= 32) begin
        checkOutput($sformatf("k2n%0d_data", n), 32'(outDataB),
                    32'({8'(n - 32), 8'(n)}));
        checkOutput($sformatf("k2n%0d_eol", n), 32'(outEolB), 32'(n == 63));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
    $finish;
  end

endmodule

// File: doc/line_buffer_rot.md
Name: line_buffer_rot

Overview:
- Parametrised rotating line buffer for the convolution datapath. Generalises the fixed 2/3/5/7-row SRAM arrays to any kernel height.
- Accepts a raster pixel stream over a valid/ready handshake and stores the last KER_SIZE-1 lines in KER_SIZE single-port SRAM banks, written round-robin.
- Emits one full kernel column (KER_SIZE pixels, oldest to newest) per accepted pixel once primed.
- Adds what the fixed arrays lack: internal column/bank counters, runtime line width, frame-start priming, backpressure and end-of-line marking.

Parameters:
- KER_SIZE, 3, kernel height = number of SRAM banks; legal range 2..9.
- DW, 32, pixel width in bits.
- NW, 32, maximum line width in pixels (words per bank).
- AW, $clog2(NW), column address width.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- cfg_width  in  AW+1  line width in pixels; sampled on an accepted SOF beat
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept a pixel
- in_sof  in  1  first pixel of frame; qualified by in_valid&in_ready
- in_data  in  DW  input pixel
- out_valid  out  1  kernel column valid
- out_ready  in  1  downstream accepts column
- out_data  out  KER_SIZE*DW  slice k = bits (k+1)*DW-1:k*DW; k=0 newest row (current pixel), k=KER_SIZE-1 oldest row
- out_eol  out  1  column is last of its line
- primed  out  1  KER_SIZE-1 full lines held since last SOF

Behaviour:
- Async reset clears col_cnt, wr_bank, line_cnt, width_q, out_valid, out_eol, primed and the pipeline data register; in_ready=1 after reset. SRAM contents are not cleared.
- width_q is loaded from cfg_width on an accepted SOF beat. A value of 0 or a value >NW loads NW. Before the first SOF, width_q=NW.
- Accept: acc = in_valid & in_ready, with in_ready = !out_valid | out_ready (single-stage pipeline, no bubble at full throughput).
- Accepted SOF beat: treated as column 0, bank 0, line_cnt=0, using the new width. Counters then advance from there.
- On acc, all banks are enabled at address col_cnt.
  - Bank wr_bank is written with in_data.
  - The other banks are read. Read-before-write: the written bank's q is don't-care.
- SRAM read latency is 1 cycle. in_data and wr_bank are registered alongside so that q and the registered data align in the output cycle.
- Output mapping: out_data slice 0 = registered in_data. Slice k (1..KER_SIZE-1) = q of bank (wr_bank_d1 - k) mod KER_SIZE. This is a generic rotate, not an enumerated case.
- When not accepting, banks are disabled (cen high), so q holds. out_data is stable while out_valid & !out_ready.
- col_cnt increments on acc. At width_q-1 it wraps to 0, wr_bank advances modulo KER_SIZE, and line_cnt increments, saturating at KER_SIZE-1.
- primed = (line_cnt == KER_SIZE-1).
- out_valid is set the cycle after an acc whose beat had primed=1 at acceptance. Unprimed beats are written but produce no output.
- out_valid is cleared on out_ready when there is no new primed acc.
- out_eol = registered (col_cnt == width_q-1) of the producing beat.
- Latency: in-beat accept to out_valid = 1 cycle.
- Simultaneous SOF and wrap: SOF wins; counters restart.
- SOF mid-line: the partial line is discarded; stale bank data is never emitted because priming restarts.
- Reset mid-stream: the output is dropped immediately (async), and the block requires a new SOF for valid output.

Test Plan:
- Prime: K=3, DW=8, cfg_width=4, SOF then pixels 1..12 with out_ready=1. Expect no out_valid for pixels 1..8. Pixel 9 gives out_data={1,5,9} (slice2..0), eol=0. Pixel 12 gives {4,8,12} with eol=1.
- Rotation: continue with pixels 13..16. Expect {5,9,13}..{8,12,16}; wr_bank has wrapped 2 to 0 and the output ordering is still correct.
- Backpressure: hold out_ready=0 for 3 cycles mid-line. Expect in_ready=0, out_data/out_valid stable, no SRAM access. On release, the next column arrives with no loss or duplication.
- Width clamp: cfg_width=0 with SOF, K=2, NW=32. Expect eol on column 31 and first output after 32 pixels.
- SOF mid-line: after 6 pixels, assert SOF. Expect primed=0, col restarts at 0, and no out_valid for the next 8 pixels (K=3, width 4).
- Async reset: assert rstn=0 while out_valid=1 and mid-clock. Expect out_valid, primed and out_eol at 0 immediately, in_ready=1 after release.
